// File: rtl/mb32_pkg.sv
// Shared types and helpers for the mb32 load/store unit.
// Sizes, FSM states and lane arithmetic used by the LSU and its bench.
package mb32_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_X = 2'b11
    } sz_t;

    typedef enum logic [2:0] {
        IDLE,
        ACC1,
        ACC2,
        CAP1,
        CAP2,
        DONE
    } lsu_state_t;

    function automatic logic [2:0] nbytes(sz_t sz);
        unique case (sz)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            SZ_W:    return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic is_split(logic [1:0] o,
                                      logic [2:0] n);
        return ({1'b0, o} + n) > 3'd4;
    endfunction

endpackage

// File: rtl/mb32_lsu_if.sv
// Core-side request/response handshake of the mb32 LSU.
// master = core, slave = LSU.
interface mb32_lsu_if #(
    parameter int ADDR_W = 17
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_sz;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_sz,
        output req_addr, req_wdata,
        input  req_ready, rsp_valid,
        input  rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_sz,
        input  req_addr, req_wdata,
        output req_ready, rsp_valid,
        output rsp_rdata, rsp_err
    );

endinterface

// File: rtl/mb32_lane_align.sv
// Big-endian lane steering: right-justified data <-> two-word window.
// Offset o, length n place the access at bytes o..o+n-1 of {A,B}.
module mb32_lane_align (
    input  logic [1:0]  o,
    input  logic [2:0]  n,
    input  logic [31:0] wdata,
    input  logic [63:0] r64,
    output logic [63:0] w64,
    output logic [7:0]  m8,
    output logic [31:0] rdata
);

    logic [2:0]  sh;
    logic [5:0]  bsh;
    logic [31:0] keep;

    always_comb begin
        // 8-o-n taken modulo 8
        sh    = 3'd0 - {1'b0, o} - n;
        bsh   = {sh, 3'b000};
        w64   = {32'h0, wdata} << bsh;
        m8    = ((8'd1 << n) - 8'd1) << sh;
        // n=4 shifts out to 0, so the mask wraps to all ones
        keep  = (32'd1 << {n, 3'b000}) - 32'd1;
        rdata = 32'(r64 >> bsh) & keep;
    end

endmodule

// File: rtl/mb32_lsu.sv
// Load/store unit between the eForth core and the 32-bit SRAM bus.
// Byte/half/word requests become one or two word cycles with masks.
module mb32_lsu
    import mb32_pkg::*;
#(
    parameter int ADDR_W   = 17,
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    mb32_lsu_if.slave         lsu,
    output logic [ADDR_W-3:0] mem_ai,
    output logic [31:0]       mem_vi,
    output logic [3:0]        mem_bmsk,
    output logic              mem_we,
    input  logic [31:0]       mem_vo
);

    lsu_state_t        state;
    logic              q_we;
    sz_t               q_sz;
    logic [ADDR_W-1:0] q_addr;
    logic [31:0]       q_wdata;
    logic [31:0]       capa;

    logic [1:0]        o;
    logic [2:0]        n;
    logic              split;
    logic [ADDR_W-3:0] wa;
    logic [ADDR_W-3:0] wb;
    logic [63:0]       w64;
    logic [63:0]       r64;
    logic [7:0]        m8;
    logic [31:0]       rdata;

    sz_t               in_sz;
    logic              in_err;
    logic              accept;

    assign o      = q_addr[1:0];
    assign n      = nbytes(q_sz);
    assign split  = is_split(o, n);
    assign wa     = q_addr[ADDR_W-1:2];
    assign wb     = wa + (ADDR_W-2)'(1);

    assign in_sz  = sz_t'(lsu.req_sz);
    assign in_err = (in_sz == SZ_X) ||
                    (!SPLIT_EN &&
                     is_split(lsu.req_addr[1:0],
                              nbytes(in_sz)));
    assign accept = lsu.req_valid && lsu.req_ready;

    // word A already captured when word B arrives
    assign r64 = (state == CAP2) ? {capa, mem_vo}
                                 : {mem_vo, 32'h0};

    mb32_lane_align u_align (
        .o     (o),
        .n     (n),
        .wdata (q_wdata),
        .r64   (r64),
        .w64   (w64),
        .m8    (m8),
        .rdata (rdata)
    );

    always_comb begin
        mem_ai   = '0;
        mem_vi   = '0;
        mem_bmsk = '0;
        mem_we   = 1'b0;
        unique case (state)
            ACC1: begin
                mem_ai = wa;
                if (q_we) begin
                    mem_vi   = w64[63:32];
                    mem_bmsk = m8[7:4];
                    mem_we   = !rst;
                end
            end
            ACC2: begin
                mem_ai = wb;
                if (q_we) begin
                    mem_vi   = w64[31:0];
                    mem_bmsk = m8[3:0];
                    mem_we   = !rst;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            q_we          <= 1'b0;
            q_sz          <= SZ_B;
            q_addr        <= '0;
            q_wdata       <= '0;
            capa          <= '0;
            lsu.req_ready <= 1'b1;
            lsu.rsp_valid <= 1'b0;
            lsu.rsp_rdata <= '0;
            lsu.rsp_err   <= 1'b0;
        end else begin
            lsu.rsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        q_we          <= lsu.req_we;
                        q_sz          <= in_sz;
                        q_addr        <= lsu.req_addr;
                        q_wdata       <= lsu.req_wdata;
                        lsu.req_ready <= 1'b0;
                        if (in_err) begin
                            state         <= DONE;
                            lsu.rsp_valid <= 1'b1;
                            lsu.rsp_err   <= 1'b1;
                            lsu.rsp_rdata <= '0;
                        end else begin
                            state <= ACC1;
                        end
                    end
                end
                ACC1: begin
                    if (split) begin
                        state <= ACC2;
                    end else if (q_we) begin
                        state         <= DONE;
                        lsu.rsp_valid <= 1'b1;
                        lsu.rsp_err   <= 1'b0;
                        lsu.rsp_rdata <= '0;
                    end else begin
                        state <= CAP1;
                    end
                end
                ACC2: begin
                    if (q_we) begin
                        state         <= DONE;
                        lsu.rsp_valid <= 1'b1;
                        lsu.rsp_err   <= 1'b0;
                        lsu.rsp_rdata <= '0;
                    end else begin
                        capa  <= mem_vo;
                        state <= CAP2;
                    end
                end
                CAP1, CAP2: begin
                    state         <= DONE;
                    lsu.rsp_valid <= 1'b1;
                    lsu.rsp_err   <= 1'b0;
                    lsu.rsp_rdata <= rdata;
                end
                DONE: begin
                    state         <= IDLE;
                    lsu.req_ready <= 1'b1;
                    lsu.rsp_err   <= 1'b0;
                end
                default: begin
                    state         <= IDLE;
                    lsu.req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mb32_lsu.sv
// Bench for mb32_lsu: SRAM bus model, byte-array reference memory,
// directed cases followed by random traffic.
module tb_mb32_lsu;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mb32_lsu_if #(.ADDR_W(17)) lsu ();
    mb32_lsu_if #(.ADDR_W(17)) lsu2 ();

    logic [14:0] mem_ai;
    logic [31:0] mem_vi;
    logic [3:0]  mem_bmsk;
    logic        mem_we;
    logic [31:0] mem_vo;

    logic [14:0] m2_ai;
    logic [31:0] m2_vi;
    logic [3:0]  m2_bmsk;
    logic        m2_we;
    logic [31:0] m2_vo = 32'h0;

    mb32_lsu #(.ADDR_W(17), .SPLIT_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .lsu(lsu),
        .mem_ai(mem_ai), .mem_vi(mem_vi),
        .mem_bmsk(mem_bmsk), .mem_we(mem_we),
        .mem_vo(mem_vo)
    );

    mb32_lsu #(.ADDR_W(17), .SPLIT_EN(1'b0)) dut2 (
        .clk(clk), .rst(rst), .lsu(lsu2),
        .mem_ai(m2_ai), .mem_vi(m2_vi),
        .mem_bmsk(m2_bmsk), .mem_we(m2_we),
        .mem_vo(m2_vo)
    );

    typedef struct {
        logic [14:0] ai;
        logic [3:0]  m;
        logic [31:0] v;
    } wr_t;

    logic [31:0] ram [0:32767];
    logic [7:0]  refb [0:131071];
    wr_t         wq[$];
    bit          inited;
    int          acc_cnt, rsp_cnt, m2_wcnt;
    int          total, bad;

    function automatic logic [31:0] initw(int w);
        return (w * 32'h9E3779B1) ^ 32'hC0FFEE11;
    endfunction

    // synchronous SRAM: write lanes by mask, read data one cycle later
    always @(posedge clk) begin
        if (!inited) begin
            for (int w = 0; w < 32768; w++) ram[w] <= initw(w);
            inited <= 1'b1;
        end else begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_bmsk[b]) ram[mem_ai][8*b +: 8] <= mem_vi[8*b +: 8];
                wq.push_back('{mem_ai, mem_bmsk, mem_vi});
            end
            mem_vo <= ram[mem_ai];
        end
        if (lsu.req_valid && lsu.req_ready) acc_cnt++;
        if (lsu.rsp_valid) rsp_cnt++;
        if (m2_we) m2_wcnt++;
    end

    function automatic int nb(logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
    endfunction

    function automatic logic [31:0] ref_load(int a, int n);
        logic [31:0] r = 0;
        for (int i = 0; i < n; i++) r = (r << 8) | 32'(refb[(a + i) % 131072]);
        return r;
    endfunction

    task automatic ref_store(int a, int n, logic [31:0] wd);
        for (int i = 0; i < n; i++) refb[(a + i) % 131072] = wd[8*(n-1-i) +: 8];
    endtask

    function automatic wr_t wr_at(int i);
        wr_t d = '{15'h7FFF, 4'hX, 32'hX};
        if (i < wq.size()) d = wq[i];
        return d;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic xact(input logic we, input logic [1:0] sz,
                        input logic [16:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er,
                        output int lat);
        int k;
        @(negedge clk);
        lsu.req_valid = 1'b1;
        lsu.req_we    = we;
        lsu.req_sz    = sz;
        lsu.req_addr  = a;
        lsu.req_wdata = wd;
        k = 0;
        while (!lsu.req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k == 20) chk("accept_timeout", 64'(k), 0);
        @(posedge clk);
        #1 lsu.req_valid = 1'b0;
        rd  = 32'h0;
        er  = 1'b0;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (lsu.rsp_valid) begin
                lat = c;
                rd  = lsu.rsp_rdata;
                er  = lsu.rsp_err;
                break;
            end
        end
        if (lat == 0) chk("rsp_timeout", 64'(lat), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, w;
        logic        er;
        int          lat, b0, a, n, ex_lat, sp;
        logic        we;
        logic [1:0]  sz;
        wr_t         e;

        rst = 1'b1;
        lsu.req_valid = 0; lsu.req_we = 0; lsu.req_sz = 0;
        lsu.req_addr = 0; lsu.req_wdata = 0;
        lsu2.req_valid = 0; lsu2.req_we = 0; lsu2.req_sz = 0;
        lsu2.req_addr = 0; lsu2.req_wdata = 0;
        for (int i = 0; i < 32768; i++) begin
            w = initw(i);
            for (int j = 0; j < 4; j++) refb[4*i + j] = w[8*(3-j) +: 8];
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", lsu.req_ready, 1);
        chk("rst_rsp_valid", lsu.rsp_valid, 0);
        chk("rst_rdata", lsu.rsp_rdata, 0);
        chk("rst_err", lsu.rsp_err, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_bmsk", mem_bmsk, 0);
        chk("rst_ai", mem_ai, 0);
        chk("rst_vi", mem_vi, 0);
        rst = 1'b0;

        // aligned word store / load
        b0 = wq.size();
        xact(1, 2'd2, 17'h0100, 32'hDEADBEEF, rd, er, lat);
        ref_store(32'h100, 4, 32'hDEADBEEF);
        e = wr_at(b0);
        chk("sw_lat", 64'(lat), 2);
        chk("sw_nwr", 64'(wq.size() - b0), 1);
        chk("sw_ai", e.ai, 15'h040);
        chk("sw_bmsk", e.m, 4'hF);
        chk("sw_vi", e.v, 32'hDEADBEEF);
        chk("sw_rdata", rd, 0);
        xact(0, 2'd2, 17'h0100, 0, rd, er, lat);
        chk("lw_data", rd, 32'hDEADBEEF);
        chk("lw_lat", 64'(lat), 3);
        chk("lw_err", er, 0);

        // byte store into the middle of the word
        b0 = wq.size();
        xact(1, 2'd0, 17'h0102, 32'hFFFFFF5A, rd, er, lat);
        ref_store(32'h102, 1, 32'h5A);
        e = wr_at(b0);
        chk("sb_bmsk", e.m, 4'b0010);
        chk("sb_vi", e.v[15:8], 8'h5A);
        xact(0, 2'd2, 17'h0100, 0, rd, er, lat);
        chk("sb_reload", rd, 32'hDEAD5AEF);
        xact(0, 2'd0, 17'h0103, 0, rd, er, lat);
        chk("lb_data", rd, 32'h000000EF);

        // misaligned word store splits across words 0x41/0x42
        b0 = wq.size();
        xact(1, 2'd2, 17'h0105, 32'h11223344, rd, er, lat);
        ref_store(32'h105, 4, 32'h11223344);
        chk("ssw_lat", 64'(lat), 3);
        chk("ssw_nwr", 64'(wq.size() - b0), 2);
        e = wr_at(b0);
        chk("ssw_a_ai", e.ai, 15'h041);
        chk("ssw_a_bmsk", e.m, 4'b0111);
        e = wr_at(b0 + 1);
        chk("ssw_b_ai", e.ai, 15'h042);
        chk("ssw_b_bmsk", e.m, 4'b1000);
        xact(0, 2'd2, 17'h0105, 0, rd, er, lat);
        chk("slw_data", rd, 32'h11223344);
        chk("slw_lat", 64'(lat), 4);

        // half at the top of memory wraps to word 0
        b0 = wq.size();
        xact(1, 2'd1, 17'h1FFFF, 32'h0000ABCD, rd, er, lat);
        ref_store(32'h1FFFF, 2, 32'hABCD);
        e = wr_at(b0);
        chk("wrap_a_ai", e.ai, 15'h7FFF);
        chk("wrap_a_bmsk", e.m, 4'b0001);
        e = wr_at(b0 + 1);
        chk("wrap_b_ai", e.ai, 15'h0000);
        chk("wrap_b_bmsk", e.m, 4'b1000);
        xact(0, 2'd1, 17'h1FFFF, 0, rd, er, lat);
        chk("wrap_load", rd, 32'h0000ABCD);

        // no-split variant rejects the same access, accepts an aligned one
        @(negedge clk);
        b0 = m2_wcnt;
        lsu2.req_valid = 1; lsu2.req_we = 1; lsu2.req_sz = 2'd1;
        lsu2.req_addr = 17'h1FFFF; lsu2.req_wdata = 32'hABCD;
        @(posedge clk);
        #1 lsu2.req_valid = 0;
        @(negedge clk);
        chk("nosplit_valid", lsu2.rsp_valid, 1);
        chk("nosplit_err", lsu2.rsp_err, 1);
        repeat (4) @(negedge clk);
        chk("nosplit_nwr", 64'(m2_wcnt - b0), 0);
        b0 = m2_wcnt;
        lsu2.req_valid = 1; lsu2.req_addr = 17'h00102;
        @(posedge clk);
        #1 lsu2.req_valid = 0;
        repeat (4) @(negedge clk);
        chk("nosplit_aligned_nwr", 64'(m2_wcnt - b0), 1);

        // illegal size
        b0 = wq.size();
        xact(1, 2'd3, 17'h0100, 32'h12345678, rd, er, lat);
        chk("ill_lat", 64'(lat), 1);
        chk("ill_err", er, 1);
        chk("ill_nwr", 64'(wq.size() - b0), 0);

        // request held high: accepted only in IDLE, every other cycle
        @(negedge clk);
        b0 = acc_cnt;
        a  = rsp_cnt;
        lsu.req_valid = 1; lsu.req_sz = 2'd3;
        repeat (8) @(posedge clk);
        #1 lsu.req_valid = 0;
        chk("b2b_accepts", 64'(acc_cnt - b0), 4);
        chk("b2b_rsps", 64'(rsp_cnt - a), 4);

        // random traffic against the byte-array reference
        for (int it = 0; it < 300; it++) begin
            we = 1'($urandom);
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = $urandom_range(0, 1) ? $urandom_range(0, 63)
                                      : 32'h1FFC0 + $urandom_range(0, 63);
            w  = $urandom;
            n  = nb(sz);
            sp = ((a % 4) + n > 4) ? 1 : 0;
            if (n == 0)  ex_lat = 1;
            else if (we) ex_lat = sp ? 3 : 2;
            else         ex_lat = sp ? 4 : 3;
            b0 = wq.size();
            xact(we, sz, 17'(a), w, rd, er, lat);
            chk("rnd_lat", 64'(lat), 64'(ex_lat));
            chk("rnd_err", er, (n == 0));
            chk("rnd_nwr", 64'(wq.size() - b0),
                (n == 0 || !we) ? 0 : 64'(1 + sp));
            if (we || n == 0) chk("rnd_rdata", rd, 0);
            else              chk("rnd_rdata", rd, ref_load(a, n));
            if (we && n != 0) ref_store(a, n, w & (32'hFFFFFFFF >> (32 - 8*n)));
        end

        // reset during the second half of a split store
        w = $urandom;
        b0 = rsp_cnt;
        @(negedge clk);
        lsu.req_valid = 1; lsu.req_we = 1; lsu.req_sz = 2'd2;
        lsu.req_addr = 17'h0205; lsu.req_wdata = w;
        @(posedge clk);
        #1 lsu.req_valid = 0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_ready", lsu.req_ready, 1);
        chk("mid_rsp_valid", lsu.rsp_valid, 0);
        chk("mid_we", mem_we, 0);
        chk("mid_bmsk", mem_bmsk, 0);
        chk("mid_ai", mem_ai, 0);
        chk("mid_rdata", lsu.rsp_rdata, 0);
        rst = 1'b0;
        chk("mid_word_b", ram[15'h082], ref_load(32'h208, 4));
        for (int i = 0; i < 3; i++) refb[32'h205 + i] = w[8*(3-i) +: 8];
        xact(0, 2'd2, 17'h0204, 0, rd, er, lat);
        chk("mid_no_rsp", 64'(rsp_cnt - b0), 1);
        chk("mid_word_a", rd, ref_load(32'h204, 4));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
